// File: rtl/pipelined_addsub_if.sv
// rtl/pipelined_addsub_if.sv - operand/result handshake bundle for pipelined_addsub
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             V;
    logic             Z;

    modport master (
        output in_valid, A, B, Cin, SUB, out_ready,
        input  in_ready, out_valid, S, Cout, V, Z
    );

    modport slave (
        input  in_valid, A, B, Cin, SUB, out_ready,
        output in_ready, out_valid, S, Cout, V, Z
    );
endinterface

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined ripple-chunk adder/subtractor with carry, overflow and zero flags
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pipelined_addsub_if.slave   bus
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    // Stage registers; operand copies only matter above the chunks already summed.
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] bop_q   [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];
    logic             valid_q [STAGES];
    logic             v_q;
    logic             z_q;

    // What each stage sees on its inputs, and what it will register.
    logic [WIDTH-1:0] a_in     [STAGES];
    logic [WIDTH-1:0] bop_in   [STAGES];
    logic [WIDTH-1:0] sum_in   [STAGES];
    logic             carry_in [STAGES];
    logic             valid_in [STAGES];
    logic [CHUNK:0]   chunk_sum[STAGES];
    logic [WIDTH-1:0] sum_d    [STAGES];
    logic             carry_d  [STAGES];
    logic             v_d;
    logic             z_d;
    logic             stall;
    logic             accept;

    // A held result freezes the whole pipe, bubbles included.
    assign stall        = valid_q[LAST] & ~bus.out_ready;
    assign accept       = bus.in_valid & ~stall;
    assign bus.in_ready = ~stall;

    // Stage 0 folds SUB into the operand and carry; later stages take the previous register.
    always_comb begin
        a_in[0]     = bus.A;
        bop_in[0]   = bus.SUB ? ~bus.B : bus.B;
        carry_in[0] = bus.Cin ^ bus.SUB;
        sum_in[0]   = '0;
        valid_in[0] = accept;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]     = a_q[k-1];
            bop_in[k]   = bop_q[k-1];
            carry_in[k] = carry_q[k-1];
            sum_in[k]   = sum_q[k-1];
            valid_in[k] = valid_q[k-1];
        end
    end

    // Each stage ripples its own chunk and merges it into the partial sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            chunk_sum[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                         + {1'b0, bop_in[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, carry_in[k]};
            sum_d[k]                    = sum_in[k];
            sum_d[k][k*CHUNK +: CHUNK]  = chunk_sum[k][CHUNK-1:0];
            carry_d[k]                  = chunk_sum[k][CHUNK];
        end
    end

    // Flags from the final chunk: carry into the MSB recovered as a ^ b ^ sum at that bit.
    always_comb begin
        v_d = a_in[LAST][WIDTH-1] ^ bop_in[LAST][WIDTH-1] ^ sum_d[LAST][WIDTH-1] ^ carry_d[LAST];
        z_d = ~|sum_d[LAST];
    end

    // Pipeline registers: cleared on reset, all advance together unless stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                bop_q[k]   <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            v_q <= 1'b0;
            z_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= a_in[k];
                bop_q[k]   <= bop_in[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_in[k];
            end
            v_q <= v_d;
            z_q <= z_d;
        end
    end

    assign bus.out_valid = valid_q[LAST];
    assign bus.S         = sum_q[LAST];
    assign bus.Cout      = carry_q[LAST];
    assign bus.V         = v_q;
    assign bus.Z         = z_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - scoreboard bench for pipelined_addsub at STAGES 4, 1 and 16
module tb_pipelined_addsub;
    localparam int W = 16;
    localparam int N = 3;   // instance 0: STAGES=4, 1: STAGES=1, 2: STAGES=16

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid_r [N];
    logic [W-1:0] a_r        [N];
    logic [W-1:0] b_r        [N];
    logic         cin_r      [N];
    logic         sub_r      [N];
    logic         out_ready_r[N];
    logic         in_ready_w [N];
    logic         out_valid_w[N];
    logic [W-1:0] s_w        [N];
    logic         cout_w     [N];
    logic         v_w        [N];
    logic         z_w        [N];

    for (genvar g = 0; g < N; g++) begin : gen_dut
        pipelined_addsub_if #(.WIDTH(W)) bus ();
        pipelined_addsub #(
            .WIDTH (W),
            .STAGES(g == 0 ? 4 : (g == 1 ? 1 : 16))
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
        assign bus.in_valid   = in_valid_r[g];
        assign bus.A          = a_r[g];
        assign bus.B          = b_r[g];
        assign bus.Cin        = cin_r[g];
        assign bus.SUB        = sub_r[g];
        assign bus.out_ready  = out_ready_r[g];
        assign in_ready_w[g]  = bus.in_ready;
        assign out_valid_w[g] = bus.out_valid;
        assign s_w[g]         = bus.S;
        assign cout_w[g]      = bus.Cout;
        assign v_w[g]         = bus.V;
        assign z_w[g]         = bus.Z;
    end

    logic [18:0] sb[N][$];
    bit          acc_r [N];
    bit          cons_r[N];
    bit          rdy_r [N];
    logic [18:0] got_r [N];
    logic [18:0] exp_r [N];
    int          tick_no = 0;
    int          errors  = 0;
    int          checks  = 0;

    logic [15:0] ta[$];
    logic [15:0] tbv[$];
    logic        tcin[$];
    logic        tsub[$];
    logic [18:0] res[$];
    int          res_t[$];
    int          acc_t[$];

    // Reference: {S, Cout, V, Z} from a WIDTH+1-bit sum, V from operand/result sign rule.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bop;
        logic [16:0] full;
        logic        v;
        bop  = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bop} + {16'h0, cin ^ sub};
        v    = (a[15] == bop[15]) && (full[15] != a[15]);
        return {full[15:0], full[16], v, (full[15:0] == 16'h0)};
    endfunction

    // One cycle: sample just after the negedge, update scoreboards, pass the posedge.
    task automatic tick();
        #1;
        for (int g = 0; g < N; g++) begin
            rdy_r[g]  = in_ready_w[g];
            acc_r[g]  = in_valid_r[g] && in_ready_w[g];
            cons_r[g] = out_valid_w[g] && out_ready_r[g];
            got_r[g]  = {s_w[g], cout_w[g], v_w[g], z_w[g]};
            if (cons_r[g]) begin
                if (sb[g].size() > 0) exp_r[g] = sb[g].pop_front();
                else                  exp_r[g] = 'x;
            end
            if (acc_r[g]) sb[g].push_back(model(a_r[g], b_r[g], cin_r[g], sub_r[g]));
        end
        tick_no++;
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int g = 0; g < N; g++) begin
            in_valid_r[g]  = 1'b0;
            a_r[g]         = '0;
            b_r[g]         = '0;
            cin_r[g]       = 1'b0;
            sub_r[g]       = 1'b0;
            out_ready_r[g] = 1'b1;
        end
    endtask

    task automatic tick_rec();
        tick();
        if (cons_r[0]) begin
            res.push_back(got_r[0]);
            res_t.push_back(tick_no - 1);
        end
    endtask

    task automatic clear_table();
        ta.delete(); tbv.delete(); tcin.delete(); tsub.delete();
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        ta.push_back(a); tbv.push_back(b); tcin.push_back(cin); tsub.push_back(sub);
    endtask

    // Drive the table into instance 0 with 'gap' idle cycles between beats, then drain.
    task automatic run_table(input int gap);
        int budget;
        res.delete(); res_t.delete(); acc_t.delete();
        out_ready_r[0] = 1'b1;
        foreach (ta[i]) begin
            in_valid_r[0] = 1'b1;
            a_r[0]   = ta[i];
            b_r[0]   = tbv[i];
            cin_r[0] = tcin[i];
            sub_r[0] = tsub[i];
            budget = 0;
            do begin
                tick_rec();
                budget++;
            end while (!acc_r[0] && budget < 20);
            acc_t.push_back(tick_no - 1);
            in_valid_r[0] = 1'b0;
            repeat (gap) tick_rec();
        end
        budget = 0;
        while (res.size() < ta.size() && budget < 40) begin
            tick_rec();
            budget++;
        end
    endtask

    task automatic test_reset();
        for (int g = 0; g < N; g++) begin
            checks++;
            if (out_valid_w[g] !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", g, out_valid_w[g]);
            end
            checks++;
            if (in_ready_w[g] !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", g, in_ready_w[g]);
            end
        end
        checks++;
        if ({s_w[0], cout_w[0], v_w[0], z_w[0]} !== 19'h0) begin
            errors++; $display("FAIL reset_flags: got %h expected 00000", {s_w[0], cout_w[0], v_w[0], z_w[0]});
        end
        rst_n = 1'b1;
        out_ready_r[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_r[0] = 1'b1;
            a_r[0] = (i == 0) ? 16'hFFFF : 16'h1234 + 16'(i);
            b_r[0] = (i == 0) ? 16'hFFFF : 16'h4321;
            tick();
        end
        in_valid_r[0] = 1'b0;
        tick();
        #1;
        checks++;
        if (out_valid_w[0] !== 1'b1) begin
            errors++; $display("FAIL reset_pre_valid: got %b expected 1", out_valid_w[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_w[0] !== 1'b0) begin
            errors++; $display("FAIL reset_async_valid: got %b expected 0", out_valid_w[0]);
        end
        checks++;
        if ({s_w[0], cout_w[0], v_w[0], z_w[0]} !== 19'h0) begin
            errors++; $display("FAIL reset_async_data: got %h expected 00000", {s_w[0], cout_w[0], v_w[0], z_w[0]});
        end
        for (int g = 0; g < N; g++) sb[g].delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle_all();
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int g = 0; g < N; g++) begin
                checks++;
                if (cons_r[g]) begin
                    errors++; $display("FAIL reset_stale[%0d]: got beat %h expected none", g, got_r[g]);
                end
            end
        end
    endtask

    task automatic test_add_boundaries();
        logic [18:0] want[2];
        want = '{{16'h8000, 1'b0, 1'b1, 1'b0}, {16'h0000, 1'b1, 1'b0, 1'b1}};
        clear_table();
        load(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        load(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_table(6);
        checks++;
        if (res.size() != 2) begin
            errors++; $display("FAIL add_count: got %0d expected 2", res.size());
        end
        for (int i = 0; i < 2 && i < res.size(); i++) begin
            checks++;
            if (res[i] !== want[i]) begin
                errors++; $display("FAIL add_value[%0d]: got %h expected %h", i, res[i], want[i]);
            end
            checks++;
            if (res_t[i] - acc_t[i] != 4) begin
                errors++; $display("FAIL add_latency[%0d]: got %0d expected 4", i, res_t[i] - acc_t[i]);
            end
        end
    endtask

    task automatic test_carry_chain();
        logic [18:0] want[3];
        want = '{{16'h1000, 3'b000}, {16'h0100, 3'b000}, {16'h0000, 3'b101}};
        clear_table();
        load(16'h0FFF, 16'h0001, 1'b0, 1'b0);
        load(16'h00FF, 16'h0001, 1'b0, 1'b0);
        load(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_table(0);
        checks++;
        if (res.size() != 3) begin
            errors++; $display("FAIL carry_count: got %0d expected 3", res.size());
        end
        for (int i = 0; i < 3 && i < res.size(); i++) begin
            checks++;
            if (res[i] !== want[i]) begin
                errors++; $display("FAIL carry_value[%0d]: got %h expected %h", i, res[i], want[i]);
            end
            if (i > 0) begin
                checks++;
                if (res_t[i] != res_t[i-1] + 1 || acc_t[i] != acc_t[i-1] + 1) begin
                    errors++; $display("FAIL carry_b2b[%0d]: got out gap %0d in gap %0d expected 1 1",
                                       i, res_t[i] - res_t[i-1], acc_t[i] - acc_t[i-1]);
                end
            end
        end
    endtask

    task automatic test_sub();
        logic [18:0] want[3];
        want = '{{16'hFFFE, 3'b000}, {16'h7FFF, 3'b110}, {16'h0000, 3'b101}};
        clear_table();
        load(16'h0005, 16'h0007, 1'b0, 1'b1);
        load(16'h8000, 16'h0001, 1'b0, 1'b1);
        load(16'h0003, 16'h0002, 1'b1, 1'b1);
        run_table(0);
        checks++;
        if (res.size() != 3) begin
            errors++; $display("FAIL sub_count: got %0d expected 3", res.size());
        end
        for (int i = 0; i < 3 && i < res.size(); i++) begin
            checks++;
            if (res[i] !== want[i]) begin
                errors++; $display("FAIL sub_value[%0d]: got %h expected %h", i, res[i], want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        int          got = 0;
        int          stall_left = 0;
        int          budget = 0;
        logic [15:0] held_s = '0;
        while (got < 8 && budget < 100) begin
            in_valid_r[0]  = (sent < 8);
            a_r[0]         = 16'h1000 + 16'(sent) * 16'h0111;
            b_r[0]         = 16'h0123;
            sub_r[0]       = sent[0];
            cin_r[0]       = sent[1];
            out_ready_r[0] = (stall_left == 0);
            tick();
            budget++;
            if (acc_r[0]) sent++;
            if (stall_left > 0) begin
                checks++;
                if (rdy_r[0] !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready: got %b expected 0", rdy_r[0]);
                end
                checks++;
                if (got_r[0][18:3] !== held_s) begin
                    errors++; $display("FAIL bp_hold: got %h expected %h", got_r[0][18:3], held_s);
                end
                stall_left--;
            end
            if (cons_r[0]) begin
                checks++;
                if (got_r[0] !== exp_r[0]) begin
                    errors++; $display("FAIL bp_order[%0d]: got %h expected %h", got, got_r[0], exp_r[0]);
                end
                if (got == 0) begin
                    stall_left = 3;
                    if (sb[0].size() > 0) held_s = sb[0][0][18:3];
                end
                got++;
            end
        end
        checks++;
        if (got != 8 || sent != 8 || sb[0].size() != 0) begin
            errors++; $display("FAIL bp_count: got %0d/%0d left %0d expected 8/8 left 0", got, sent, sb[0].size());
        end
        idle_all();
    endtask

    task automatic test_random();
        int sent[N];
        int got[N];
        int budget = 0;
        bit done;
        for (int g = 0; g < N; g++) begin
            sent[g] = 0;
            got[g]  = 0;
        end
        while (budget < 30000) begin
            done = 1'b1;
            for (int g = 0; g < N; g++) if (got[g] < 2000) done = 1'b0;
            if (done) break;
            for (int g = 0; g < N; g++) begin
                in_valid_r[g]  = (sent[g] < 2000) && ($urandom_range(0, 9) < 7);
                a_r[g]         = 16'($urandom);
                b_r[g]         = 16'($urandom);
                cin_r[g]       = 1'($urandom_range(0, 1));
                sub_r[g]       = 1'($urandom_range(0, 1));
                out_ready_r[g] = ($urandom_range(0, 9) < 7) || (sent[g] >= 2000);
            end
            tick();
            budget++;
            for (int g = 0; g < N; g++) begin
                if (acc_r[g]) sent[g]++;
                if (cons_r[g]) begin
                    checks++;
                    if (got_r[g] !== exp_r[g]) begin
                        errors++; $display("FAIL rand[%0d] beat %0d: got %h expected %h", g, got[g], got_r[g], exp_r[g]);
                    end
                    got[g]++;
                end
            end
        end
        for (int g = 0; g < N; g++) begin
            checks++;
            if (got[g] != 2000 || sb[g].size() != 0) begin
                errors++; $display("FAIL rand_count[%0d]: got %0d left %0d expected 2000 left 0", g, got[g], sb[g].size());
            end
        end
        idle_all();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(negedge clk);
        test_reset();
        test_add_boundaries();
        test_carry_chain();
        test_sub();
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
